// File: rtl/usr_burst.sv
// rtl/usr_burst.sv - universal shift register with autonomous burst sequencer
module usr_burst #(
  parameter int N  = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [LW-1:0] len,
  input  logic          sin,
  input  logic [N-1:0]  pin,
  output logic          busy,
  output logic          done,
  output logic          sout,
  output logic [N-1:0]  pout
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  q, q_nx;
  logic [LW-1:0] rem, rem_nx;
  logic [2:0]    mode_r, mode_nx;
  logic          dir, dir_nx;  // 1 = right-going, sout taps q[0]

  function automatic logic [N-1:0] step(input logic [2:0] m, input logic [N-1:0] v,
                                        input logic s);
    case (m)
      M_SHL:   step = {v[N-2:0], s};
      M_SHR:   step = {s, v[N-1:1]};
      M_ROL:   step = {v[N-2:0], v[N-1]};
      M_ROR:   step = {v[0], v[N-1:1]};
      M_ASR:   step = {v[N-1], v[N-1:1]};
      default: step = v;
    endcase
  endfunction

  always_comb begin
    state_nx = state;
    q_nx     = q;
    rem_nx   = rem;
    mode_nx  = mode_r;
    dir_nx   = dir;
    case (state)
      S_IDLE, S_DONE: begin
        state_nx = S_IDLE;
        if (start) begin
          state_nx = S_DONE;
          case (mode)
            M_SHL, M_SHR, M_ROL, M_ROR, M_ASR: begin
              dir_nx = (mode == M_SHR) || (mode == M_ROR) || (mode == M_ASR);
              if (len != '0) begin
                mode_nx  = mode;
                rem_nx   = len;
                state_nx = S_RUN;
              end
            end
            M_LOAD: begin
              q_nx   = pin;
              dir_nx = 1'b0;
            end
            default: dir_nx = 1'b0;
          endcase
        end
      end
      S_RUN: begin
        q_nx   = step(mode_r, q, sin);
        rem_nx = rem - LW'(1);
        if (rem == LW'(1)) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      q      <= '0;
      rem    <= '0;
      mode_r <= M_HOLD;
      dir    <= 1'b0;
    end else begin
      state  <= state_nx;
      q      <= q_nx;
      rem    <= rem_nx;
      mode_r <= mode_nx;
      dir    <= dir_nx;
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign sout = dir ? q[0] : q[N-1];
  assign pout = q;

endmodule

// File: tb/tb_usr_burst.sv
// tb/tb_usr_burst.sv - randomized self-checking bench for usr_burst
module tb_usr_burst;

  logic       clk = 1'b0;
  logic       rst, start, sin;
  logic [2:0] mode;
  logic [3:0] len;
  logic [7:0] pin;
  logic       busy, done, sout;
  logic [7:0] pout;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq;
  logic       mdir;

  usr_burst #(.N(8), .LW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len), .sin(sin),
    .pin(pin), .busy(busy), .done(done), .sout(sout), .pout(pout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result of a whole operation from the mode's arithmetic meaning; sb[j] is sin at shift j.
  function automatic logic [7:0] ref_q(input logic [7:0] q, input logic [2:0] m,
                                       input int l, input logic [7:0] p, input logic [15:0] sb);
    longint w;
    int k;
    logic signed [7:0] s;
    w = q;
    case (m)
      3'd3: return p;
      3'd1: begin
        w = w << l;
        for (int j = 0; j < l; j++) if (sb[j]) w = w | (64'd1 << (l - 1 - j));
        return w[7:0];
      end
      3'd2: begin
        for (int j = 0; j < l; j++) if (sb[j]) w = w | (64'd1 << (8 + j));
        w = w >> l;
        return w[7:0];
      end
      3'd4: begin
        k = l % 8;
        w = (w << k) | (w >> (8 - k));
        return w[7:0];
      end
      3'd5: begin
        k = l % 8;
        w = (w >> k) | (w << (8 - k));
        return w[7:0];
      end
      3'd6: begin
        s = q;
        s = s >>> ((l > 7) ? 7 : l);
        return s;
      end
      default: return q;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] m, input logic [3:0] l, input logic [7:0] p,
                       input logic [15:0] sb, input bit poke);
    int cyc;
    logic [7:0] q0;
    bit shift;
    q0 = mq;
    shift = (m inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6}) && (l != 0);
    start = 1'b1; mode = m; len = l; pin = p; sin = sb[0];
    tick();
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin
      chk("run_pout", pout, ref_q(q0, m, cyc, p, sb));
      if (poke && cyc == 1) begin
        start = 1'b1; mode = 3'd3; pin = 8'hFF;
      end else start = 1'b0;
      sin = sb[cyc % 16];
      tick();
      cyc++;
    end
    start = 1'b0;
    mq = ref_q(q0, m, l, p, sb);
    mdir = (m == 3'd2) || (m == 3'd5) || (m == 3'd6);
    chk("busy_cycles", cyc, shift ? l : 0);
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 0);
    chk("pout", pout, mq);
    chk("sout", sout, mdir ? mq[0] : mq[7]);
    tick();
    chk("done_clear", done, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = '0; len = '0; sin = 1'b0; pin = '0;
    mq = '0; mdir = 1'b0;
    tick(); tick();
    chk("rst_pout", pout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sout", sout, 0);
    rst = 1'b1;
    tick();

    // ROL across the MSB
    do_op(3'd3, 0, 8'h81, 16'h0, 0);
    do_op(3'd4, 3, 8'h00, 16'h0, 0);
    chk("rol3_val", pout, 8'h0C);
    chk("rol3_sout", sout, 0);

    // ASR longer than N saturates; full ROR wrap
    do_op(3'd3, 0, 8'h80, 16'h0, 0);
    do_op(3'd6, 10, 8'h00, 16'h0, 0);
    chk("asr10_val", pout, 8'hFF);
    do_op(3'd3, 0, 8'h3C, 16'h0, 0);
    do_op(3'd5, 8, 8'h00, 16'h0, 0);
    chk("ror8_val", pout, 8'h3C);

    // SHR with sin 1,0,1,1
    do_op(3'd3, 0, 8'h00, 16'h0, 0);
    do_op(3'd2, 4, 8'h00, 16'b1101, 0);
    chk("shr4_val", pout, 8'hD0);

    // start during RUN is ignored
    do_op(3'd3, 0, 8'h0F, 16'h0, 0);
    do_op(3'd1, 4, 8'h00, 16'h0, 1);
    chk("poke_ignored", (pout == 8'hFF), 0);
    chk("poke_val", pout, 8'hF0);

    // hold and len=0 leave q alone but update direction
    do_op(3'd3, 0, 8'h43, 16'h0, 0);
    do_op(3'd0, 7, 8'hFF, 16'h0, 0);
    chk("hold_val", pout, 8'h43);
    do_op(3'd2, 0, 8'hFF, 16'h0, 0);
    chk("len0_sout", sout, 1);
    do_op(3'd7, 3, 8'hFF, 16'h0, 0);
    chk("rsvd_sout", sout, 0);

    // back-to-back: load then SHL accepted in the DONE cycle
    start = 1'b1; mode = 3'd3; pin = 8'h5A; len = 0;
    tick();
    chk("b2b_done1", done, 1);
    mode = 3'd1; len = 1; sin = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_nodone", done, 0);
    tick();
    chk("b2b_done2", done, 1);
    chk("b2b_val", pout, 8'hB5);
    tick();
    mq = 8'hB5; mdir = 1'b0;

    // reset mid-burst
    do_op(3'd3, 0, 8'hA5, 16'h0, 0);
    start = 1'b1; mode = 3'd1; len = 5; sin = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    tick();
    chk("mrst_pout", pout, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_sout", sout, 0);
    rst = 1'b1;
    mq = '0; mdir = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_nodone", {busy, done}, 0);
    end

    // randomized operations against the reference
    for (int i = 0; i < 40; i++) begin
      int gap;
      do_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 8'($urandom),
            16'($urandom), bit'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        chk("idle_pout", pout, mq);
        chk("idle_flags", {busy, done}, 0);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
